// File: rtl/dz_scan_decoder.sv
// rtl/dz_scan_decoder.sv - dot-matrix scan receiver that rebuilds 8x8 frames and decodes font digits
//
// Purpose:
//   Samples the row-multiplexed red/green scan stream of the 8x8 dot-matrix
//   driver, rebuilds the full frame, compares it to the digit font (0..5) and
//   reports digit, exact-match flag and colour with a one-cycle valid pulse.
//
// Ports:
//   clk          scan clock (shared with the driver)
//   rst          asynchronous active-high reset
//   row[7:0]     row strobe, active-low one-hot (bit i low selects row i)
//   colr[7:0]    red column data of the strobed row, active-high
//   colg[7:0]    green column data of the strobed row, active-high
//   frame_valid  one-cycle pulse: a complete frame was decoded
//   num[2:0]     decoded digit 0..5, 3'd7 when no glyph matches
//   match        frame equals a glyph on both planes
//   color[1:0]   00 blank, 01 red, 10 green, 11 yellow
//   changed      pulses with frame_valid when num differs from the previous num
//   err          one-cycle pulse on an illegal row code or out-of-sequence row
//   lost         level: no legal row seen for TIMEOUT_CYC cycles

module dz_scan_decoder #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] row,
    input  logic [7:0] colr,
    input  logic [7:0] colg,
    output logic       frame_valid,
    output logic [2:0] num,
    output logic       match,
    output logic [1:0] color,
    output logic       changed,
    output logic       err,
    output logic       lost
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_MATCH = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
    localparam int         NGLYPH      = 6;

    // Glyph planes packed with row 0 in the most significant byte, so the
    // literals read top row first.
    localparam logic [63:0] GLYPH_R [NGLYPH] = '{
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000,
        64'h3C66_0600_0C30_607E,
        64'h3C66_061C_0666_3C00,
        64'h0C1C_2C4C_7E0C_0C00,
        64'h7E60_7C06_0666_3C00
    };
    localparam logic [63:0] GLYPH_G [NGLYPH] = '{
        64'h003C_4242_4242_423C,
        64'h0018_1838_1818_187E,
        64'h3C66_0600_0C30_607E,
        64'h3C66_061C_0666_3C00,
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000
    };

    state_t      state_q;
    logic [2:0]  exp_q;
    logic [63:0] red_q;
    logic [63:0] green_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;

    logic        frame_valid_q;
    logic [2:0]  num_q;
    logic        match_q;
    logic [1:0]  color_q;
    logic        changed_q;
    logic        err_q;
    logic        lost_q;

    logic [3:0]  zero_cnt;
    logic [2:0]  row_idx;
    logic        row_legal;
    logic [5:0]  row_lsb;
    logic [2:0]  exp_eff;
    logic [2:0]  glyph_num;
    logic        glyph_hit;
    logic [1:0]  glyph_color;

    // Row decode: legal only with exactly one low bit.
    always_comb begin
        zero_cnt = 4'd0;
        row_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!row[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                row_idx  = 3'(i);
            end
        end
        row_legal = (zero_cnt == 4'd1);
    end

    // Bit offset of the strobed row inside the packed 64-bit planes.
    assign row_lsb = {3'd7 - row_idx, 3'b000};

    // The MATCH cycle treats its incoming row as the first row of a new
    // frame, which is what lets back-to-back frames decode without a gap.
    assign exp_eff = (state_q == ST_MATCH) ? 3'd0 : exp_q;

    // Glyph lookup on the completed frame; glyphs are all distinct, the
    // descending scan only fixes priority for the synthesiser.
    always_comb begin
        glyph_num = 3'd7;
        glyph_hit = 1'b0;
        for (int g = NGLYPH - 1; g >= 0; g--) begin
            if ((red_q == GLYPH_R[g]) && (green_q == GLYPH_G[g])) begin
                glyph_num = 3'(g);
                glyph_hit = 1'b1;
            end
        end
        glyph_color = {|green_q, |red_q};
    end

    // Idle-cycle counter, saturating at the timeout.
    always_comb begin
        if (row_legal) begin
            cnt_d = 8'd0;
        end else if (cnt_q == TIMEOUT_LIM) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            exp_q         <= 3'd0;
            red_q         <= 64'd0;
            green_q       <= 64'd0;
            cnt_q         <= 8'd0;
            frame_valid_q <= 1'b0;
            num_q         <= 3'd7;
            match_q       <= 1'b0;
            color_q       <= 2'b00;
            changed_q     <= 1'b0;
            err_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= cnt_d;
            lost_q        <= (cnt_d == TIMEOUT_LIM);

            // num_q only moves on frame_valid, so it doubles as the
            // previous-digit register for the changed flag.
            if (state_q == ST_MATCH) begin
                frame_valid_q <= 1'b1;
                num_q         <= glyph_num;
                match_q       <= glyph_hit;
                color_q       <= glyph_color;
                changed_q     <= (glyph_num != num_q);
            end

            case (state_q)
                ST_IDLE: begin
                    if (!row_legal) begin
                        err_q <= 1'b1;
                    end else if (row_idx == 3'd0) begin
                        red_q[row_lsb +: 8]   <= colr;
                        green_q[row_lsb +: 8] <= colg;
                        exp_q                 <= 3'd1;
                        state_q               <= ST_CAPT;
                    end
                end

                ST_CAPT, ST_MATCH: begin
                    if (!row_legal) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (row_idx == exp_eff) begin
                        red_q[row_lsb +: 8]   <= colr;
                        green_q[row_lsb +: 8] <= colg;
                        exp_q                 <= exp_eff + 3'd1;
                        state_q               <= (row_idx == 3'd7) ? ST_MATCH : ST_CAPT;
                    end else begin
                        err_q <= 1'b1;
                        // A fresh row 0 restarts capture instead of dropping
                        // back to idle, so a resync costs no extra frame.
                        if (row_idx == 3'd0) begin
                            red_q[row_lsb +: 8]   <= colr;
                            green_q[row_lsb +: 8] <= colg;
                            exp_q                 <= 3'd1;
                            state_q               <= ST_CAPT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_valid = frame_valid_q;
    assign num         = num_q;
    assign match       = match_q;
    assign color       = color_q;
    assign changed     = changed_q;
    assign err         = err_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_dz_scan_decoder.sv
// tb/tb_dz_scan_decoder.sv - self-checking bench for dz_scan_decoder with a frame-level reference model

module tb_dz_scan_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] row = 8'hFF;
    logic [7:0] colr = 8'h00;
    logic [7:0] colg = 8'h00;
    logic       frame_valid;
    logic [2:0] num;
    logic       match;
    logic [1:0] color;
    logic       changed;
    logic       err;
    logic       lost;

    dz_scan_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .colr        (colr),
        .colg        (colg),
        .frame_valid (frame_valid),
        .num         (num),
        .match       (match),
        .color       (color),
        .changed     (changed),
        .err         (err),
        .lost        (lost)
    );

    always #5 clk = ~clk;

    logic [7:0] GR [6][8] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h00, 8'h0C, 8'h30, 8'h60, 8'h7E},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00}
    };
    logic [7:0] GG [6][8] = '{
        '{8'h00, 8'h3C, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h3C},
        '{8'h00, 8'h18, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h7E},
        '{8'h3C, 8'h66, 8'h06, 8'h00, 8'h0C, 8'h30, 8'h60, 8'h7E},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many rows of the current frame were
    // accepted and decodes a frame one cycle after its last row.
    int         m_fv = 0, m_num = 7, m_match = 0, m_color = 0;
    int         m_changed = 0, m_err = 0, m_lost = 0;
    bit         m_in_frame = 1'b0;
    bit         m_complete = 1'b0;
    int         m_prog = 0;
    int         m_idle = 0;
    int         m_zeros, m_idx, m_dig;
    bit         m_rany, m_gany;
    logic [7:0] mb_r [8];
    logic [7:0] mb_g [8];

    function automatic int glyph_lookup();
        for (int g = 0; g < 6; g++) begin
            int same;
            same = 1;
            for (int i = 0; i < 8; i++) begin
                if (mb_r[i] != GR[g][i] || mb_g[i] != GG[g][i]) same = 0;
            end
            if (same == 1) return g;
        end
        return 7;
    endfunction

    function automatic logic [7:0] row_code(input int i);
        logic [7:0] v;
        v = 8'h01 << i;
        return ~v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fv = 0; m_num = 7; m_match = 0; m_color = 0;
            m_changed = 0; m_err = 0; m_lost = 0;
            m_in_frame = 1'b0; m_complete = 1'b0; m_prog = 0; m_idle = 0;
            for (int i = 0; i < 8; i++) begin
                mb_r[i] = 8'h00;
                mb_g[i] = 8'h00;
            end
        end else begin
            if (m_complete) begin
                m_dig = glyph_lookup();
                m_rany = 1'b0;
                m_gany = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (mb_r[i] != 8'h00) m_rany = 1'b1;
                    if (mb_g[i] != 8'h00) m_gany = 1'b1;
                end
                m_fv      = 1;
                m_changed = (m_dig != m_num) ? 1 : 0;
                m_num     = m_dig;
                m_match   = (m_dig != 7) ? 1 : 0;
                m_color   = (m_gany ? 2 : 0) + (m_rany ? 1 : 0);
            end else begin
                m_fv      = 0;
                m_changed = 0;
            end
            m_complete = 1'b0;

            m_zeros = $countones(~row);
            m_idx = 0;
            for (int i = 0; i < 8; i++) if (!row[i]) m_idx = i;
            m_err = 0;
            if (m_zeros != 1) begin
                m_err = 1;
                m_in_frame = 1'b0;
            end else if (!m_in_frame) begin
                if (m_idx == 0) begin
                    mb_r[0] = colr; mb_g[0] = colg;
                    m_in_frame = 1'b1; m_prog = 1;
                end
            end else if (m_idx == m_prog) begin
                mb_r[m_idx] = colr; mb_g[m_idx] = colg;
                m_prog++;
                if (m_prog == 8) begin
                    m_complete = 1'b1;
                    m_prog = 0;
                end
            end else begin
                m_err = 1;
                if (m_idx == 0) begin
                    mb_r[0] = colr; mb_g[0] = colg;
                    m_prog = 1;
                end else begin
                    m_in_frame = 1'b0;
                end
            end

            if (m_zeros == 1) m_idle = 0;
            else if (m_idle < TO) m_idle++;
            m_lost = (m_idle == TO) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("frame_valid", frame_valid, m_fv);
            chk("num", num, m_num);
            chk("match", match, m_match);
            chk("color", color, m_color);
            chk("changed", changed, m_changed);
            chk("err", err, m_err);
            chk("lost", lost, m_lost);
        end
    end

    task automatic drive(input logic [7:0] r, input logic [7:0] cr, input logic [7:0] cg);
        row  = r;
        colr = cr;
        colg = cg;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_rows(input int d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive(row_code(i), GR[d][i], GG[d][i]);
    endtask

    task automatic send_frame_rand(input int d, input bit corrupt);
        int         crow, cbit, cpl;
        logic [7:0] cr, cg, mask;
        crow = $urandom_range(0, 7);
        cbit = $urandom_range(0, 7);
        cpl  = $urandom_range(0, 1);
        mask = 8'h01 << cbit;
        for (int i = 0; i < 8; i++) begin
            cr = GR[d][i];
            cg = GG[d][i];
            if (corrupt && i == crow) begin
                if (cpl == 0) cr = cr ^ mask;
                else          cg = cg ^ mask;
            end
            drive(row_code(i), cr, cg);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_num", num, 7);
        chk("rst_match", match, 0);
        chk("rst_color", color, 0);
        chk("rst_changed", changed, 0);
        chk("rst_err", err, 0);
        chk("rst_lost", lost, 0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Digit 3 back-to-back: changed only on the first frame.
        send_rows(3, 0, 7);
        send_rows(3, 0, 0);
        chk("d3_fv", frame_valid, 1);
        chk("d3_num", num, 3);
        chk("d3_match", match, 1);
        chk("d3_color", color, 3);
        chk("d3_changed", changed, 1);
        send_rows(3, 1, 7);
        send_rows(1, 0, 0);
        chk("d3b_fv", frame_valid, 1);
        chk("d3b_changed", changed, 0);

        // Switch 1 -> 4 at frame boundaries.
        send_rows(1, 1, 7);
        send_rows(4, 0, 0);
        chk("d1_num", num, 1);
        chk("d1_color", color, 2);
        chk("d1_changed", changed, 1);
        send_rows(4, 1, 7);
        drive(8'hFF, 8'h00, 8'h00);
        chk("d4_num", num, 4);
        chk("d4_color", color, 1);
        chk("d4_changed", changed, 1);
        chk("d4_err_with_fv", err, 1);

        // Row 4 skipped.
        send_rows(2, 0, 3);
        send_rows(2, 5, 5);
        chk("skip_err", err, 1);
        chk("skip_fv", frame_valid, 0);
        send_rows(2, 6, 7);
        send_rows(2, 0, 7);
        drive(8'hFF, 8'h00, 8'h00);
        chk("d2_fv", frame_valid, 1);
        chk("d2_num", num, 2);

        // Two-zero row code mid-frame.
        send_rows(3, 0, 2);
        drive(8'hF3, 8'h00, 8'h00);
        chk("f3_err", err, 1);
        chk("f3_num_hold", num, 2);

        // Timeout.
        drive(row_code(5), 8'h00, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            drive(8'hFF, 8'h00, 8'h00);
            if (k == 15) chk("lost_15", lost, 0);
            if (k == 16) chk("lost_16", lost, 1);
            if (k == 20) chk("lost_20", lost, 1);
        end
        drive(row_code(5), 8'h00, 8'h00);
        chk("lost_clear", lost, 0);

        // Asynchronous reset mid-frame.
        send_rows(5, 0, 7);
        send_rows(5, 0, 0);
        chk("d5_num", num, 5);
        send_rows(5, 1, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_num", num, 7);
        chk("arst_color", color, 0);
        chk("arst_match", match, 0);
        @(negedge clk);
        rst = 1'b0;

        // Digit 0 with one stray red pixel: no match, yellow, no change from 7.
        for (int i = 0; i < 8; i++) drive(row_code(i), (i == 2) ? 8'h01 : 8'h00, GG[0][i]);
        drive(8'hFF, 8'h00, 8'h00);
        chk("bad0_fv", frame_valid, 1);
        chk("bad0_num", num, 7);
        chk("bad0_match", match, 0);
        chk("bad0_color", color, 3);
        chk("bad0_changed", changed, 0);

        // Randomised traffic against the model.
        for (int it = 0; it < 260; it++) begin
            int mode, d, n;
            mode = $urandom_range(0, 9);
            d    = $urandom_range(0, 5);
            if (mode <= 5) begin
                send_frame_rand(d, ($urandom_range(0, 7) == 0));
            end else if (mode == 6) begin
                n = $urandom_range(1, 6);
                send_rows(d, 0, n - 1);
                if ($urandom_range(0, 1) == 1)
                    drive(row_code($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                else
                    drive(8'($urandom), 8'($urandom), 8'($urandom));
            end else if (mode == 7) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        drive(row_code($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                    else
                        drive(8'($urandom), 8'($urandom), 8'($urandom));
                end
            end else if (mode == 8) begin
                n = $urandom_range(1, 20);
                for (int k = 0; k < n; k++) drive(8'hFF, 8'h00, 8'h00);
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    #2 rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    send_frame_rand(d, 1'b0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dz_scan_decoder.md
Name: dz_scan_decoder

Overview:
- Panel-side receiver for the 8x8 red/green dot-matrix scan interface (row, colr, colg) produced by the team's dot-matrix driver.
- Samples the row-multiplexed stream and rebuilds the full 8-row frame.
- Matches the frame against the team's digit font (0–5) and reports the decoded digit and colour with a one-cycle valid pulse.
- Used for board self-test and loopback checking of the counter/display path. Runs on the same 1 kHz scan clock as the driver.

Parameters:
- TIMEOUT_CYC, 16: cycles with no legal row strobe before `lost` asserts (range 9–255).

Ports:
- clk  in  1  scan clock (1 kHz, same as driver)
- rst  in  1  reset
- row  in  8  row strobe, active-low one-hot; bit i low selects row i
- colr  in  8  red column data for strobed row, active-high
- colg  in  8  green column data for strobed row, active-high
- frame_valid  out  1  one-cycle pulse: new frame decoded
- num  out  3  decoded digit 0–5; 3'd7 = no font match
- match  out  1  frame equals a font glyph exactly (both planes)
- color  out  2  00 blank, 01 red, 10 green, 11 yellow
- changed  out  1  one-cycle pulse with frame_valid when num differs from previous decoded num
- err  out  1  one-cycle pulse on illegal row code or out-of-sequence row
- lost  out  1  level: no legal row for TIMEOUT_CYC cycles

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: frame_valid=0, num=3'd7, match=0, color=00, changed=0, err=0, lost=0. Frame buffers (8x8 red, 8x8 green) cleared, state=IDLE, timeout counter=0, previous num=3'd7.
- Sampling: row, colr and colg are sampled together on every rising clk. They are aligned on the same cycle; no extra skew stage.
- Row decode:
  - legal = exactly one zero bit in row; idx = position of that zero.
  - row=8'hFF or more than one zero bit is illegal.
- FSM states:
  - IDLE: on legal idx=0, store row 0 and go to CAPT with exp=1. Any other legal idx is ignored silently. Illegal codes pulse err.
  - CAPT: on legal idx==exp, store row idx and set exp=exp+1.
    - If idx==7, store row 7 and go to MATCH.
    - If idx!=exp, pulse err and discard the partial frame. If idx==0, restart capture (store row 0, exp=1); otherwise go to IDLE.
    - Illegal code: pulse err, go to IDLE.
  - MATCH (one cycle): compare the buffers with the glyph table, register the outputs, and pulse frame_valid.
    - The row sampled during MATCH is processed as in CAPT with exp=0, so continuous back-to-back frames are decoded without loss.
- Latency: row 7 is sampled at edge N; frame_valid, num, match, color and changed update at edge N+1. num, match and color hold until the next frame_valid.
- Glyph table, rows 0..7, hex, red plane / green plane:
  - 0: R all 00 / G 00,3C,42,42,42,42,42,3C
  - 1: R all 00 / G 00,18,18,38,18,18,18,7E
  - 2: R = G = 3C,66,06,00,0C,30,60,7E
  - 3: R = G = 3C,66,06,1C,06,66,3C,00
  - 4: R 0C,1C,2C,4C,7E,0C,0C,00 / G all 00
  - 5: R 7E,60,7C,06,06,66,3C,00 / G all 00
- Match rule: exact equality on all 128 bits. If nothing matches, num=7 and match=0.
- Colour rule, from OR-reduction of each plane:
  - r_any and g_any: 11
  - r_any only: 01
  - g_any only: 10
  - neither: 00
  - Colour is computed even when match=0.
- changed = frame_valid and (new num != previous num). Previous num updates on every frame_valid. The first frame after reset with num=7 does not pulse changed.
- Timeout:
  - The counter clears on every legal row and increments otherwise, saturating at TIMEOUT_CYC.
  - lost=1 while counter==TIMEOUT_CYC; it clears on the cycle after the next legal row.
  - lost does not alter FSM state.
- Simultaneous events: err and frame_valid may assert in the same cycle (MATCH cycle receiving a bad row); both are reported.
- Reset mid-frame: the partial frame is discarded and outputs return to reset values immediately.

Test Plan:
- Drive digit 3 glyph rows 0..7 continuously -> frame_valid pulses every 8 cycles, num=3, match=1, color=11, changed=1 on first frame only.
- Drive digit 1 then switch to digit 4 at a frame boundary -> first frames num=1/color=10; switch frame num=4/color=01 with changed=1.
- Skip row 4 (rows 0,1,2,3,5) -> err pulse at row 5 sample, no frame_valid; the next clean frame decodes normally.
- Drive row=8'hF3 (two zeros) in mid-frame -> err pulse, FSM to IDLE, num keeps its previous value.
- Hold row=8'hFF for 20 cycles -> lost=1 from cycle 16; first legal row clears lost the following cycle.
- Digit 0 glyph with colr row 2 bit 0 set -> num=7, match=0, color=11; assert rst mid-frame -> all outputs return to reset values asynchronously.
